ifetch_prefetch: RTL

//  Instruction-fetch front end for the mips_32 core. Issues word-addressed reads to a

---
 rtl/ifetch_prefetch_pkg.sv | 33 +++
 rtl/ifetch_prefetch_if.sv | 40 ++++
 rtl/ifetch_fifo.sv | 71 +++++++
 rtl/ifetch_prefetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: word type, fetch-entry struct {pc, instr}, FSM state enum,
// default reset PC and the sequential word-address PC step.
package ifetch_prefetch_pkg;

    localparam int          WORD_W       = 32;
    localparam int          ENTRY_W      = 2 * WORD_W;   // pc + instr
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef logic [WORD_W-1:0] word_t;

    // Field order puts the PC in the upper half so a packed compare of
    // {pc, instr} lines up with the struct.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_t;

    // PCs are word addresses, so the next sequential fetch is +1; the
    // 32-bit add wraps FFFF_FFFF back to 0.
    function automatic word_t pc_next(word_t pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bundles the redirect, instruction-memory and decode-side handshakes.
// Latency: n/a (wires only).
// Backpressure: carries imem_gnt (request stall) and if_ready (consumer stall).
//
// master: the fetch unit (drives imem_req/imem_addr and the if_* outputs).
// slave : the environment (core next-PC logic, instruction memory, decode).
interface ifetch_prefetch_if;
    import ifetch_prefetch_pkg::*;

    logic  redirect;
    word_t redirect_pc;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;

    logic  if_valid;
    logic  if_ready;
    word_t if_instr;
    word_t if_pc;

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with flush.
// Latency: an entry pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk, reset_n (async, active low); push/push_dat; pop; flush (wins over
// push and pop); head_dat (zero while empty); count, empty, full.
module ifetch_fifo
    import ifetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push-at-full is legal then.
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the consumer-facing outputs are
    // clean after reset and after a flush.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: issues imem reads, buffers {pc, instr}, feeds decode.
// Latency: imem latency + 1 from grant to if_valid (registered FIFO, no bypass).
// Backpressure: requests are credit-limited by outstanding reads and FIFO space.
//
// Ports: clk, reset_n (async, active low); bus (ifetch_prefetch_if.master):
//   redirect/redirect_pc  flush and restart fetch at a new word address
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata  in-order memory port
//   if_valid/if_ready/if_instr/if_pc                     decode handshake
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    ifetch_prefetch_if.master  bus
);

    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_nxt;

    word_t            fetch_pc;     // address of the next request to issue
    word_t            resp_pc;      // address of the oldest live request
    logic [CNT_W-1:0] outstanding;  // granted, not yet answered (live + stale)
    logic [CNT_W-1:0] stale;        // answers still owed to flushed requests

    logic             imem_req_c;
    logic             accept;
    logic             rvalid;
    logic             drop;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;

    fetch_entry_t     push_dat;
    fetch_entry_t     head_dat;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // ------------------------------------------------------------------
    // FSM: one idle cycle after reset release, then RUN forever. Draining
    // after a redirect is carried by the stale counter, not by a state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Every outstanding request may still land in the FIFO, so counting
    // it against the free space up front makes overflow impossible. Stale
    // requests are counted too; they drain within a few cycles.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

    always_comb begin
        state_nxt  = state;
        imem_req_c = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                state_nxt  = ST_RUN;
                imem_req_c = !bus.redirect
                          && (outstanding < MAX_OUT_C)
                          && (credit_used < DEPTH_C);
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request / response bookkeeping
    // ------------------------------------------------------------------
    assign accept = imem_req_c && bus.imem_gnt;
    assign rvalid = bus.imem_rvalid;
    assign drop   = rvalid && (stale != '0);
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push   = rvalid && !drop && !bus.redirect;
    assign pop    = bus.if_valid && bus.if_ready;

    assign push_dat = '{pc: resp_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                resp_pc  <= bus.redirect_pc;
                // Everything in flight is now stale, except a word landing
                // this very cycle, which is discarded right here.
                stale    <= outstanding - CNT_W'(rvalid);
            end else begin
                if (accept) begin
                    fetch_pc <= pc_next(fetch_pc);
                end
                if (push) begin
                    resp_pc <= pc_next(resp_pc);
                end
                if (drop) begin
                    stale <= stale - 1'b1;
                end
            end
            // accept is already 0 in a redirect cycle, so this is uniform.
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rvalid);
        end
    end

    // ------------------------------------------------------------------
    // Prefetch buffer; redirect flushes it and voids a same-cycle pop.
    // ------------------------------------------------------------------
    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (bus.redirect),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // ------------------------------------------------------------------
    // Outputs. imem_addr is the registered fetch_pc, so it naturally holds
    // while a request waits for its grant.
    // ------------------------------------------------------------------
    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_instr  = head_dat.instr;
    assign bus.if_pc     = head_dat.pc;

    // fifo_full is implied by the credit check; it is kept on the FIFO
    // port for reuse and left unused here.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
